// File: rtl/ravenoc_link_slice_pkg.sv
// Shared constants and types for the inter-router link slice.
// The mesh top reads LINK_SLICE_EN to pick a slice or a plain wire per link.
package ravenoc_link_slice_pkg;

    localparam int N_VIRT_CHN       = 2;
    localparam int FLIT_WIDTH       = 34;
    localparam int LINK_SLICE_DEPTH = 2;

    // One bit per mesh link; a set bit places a slice on that link.
    localparam logic [31:0] LINK_SLICE_EN = 32'hFFFF_FFFF;

    function automatic int vc_id_width(input int n_vc);
        return (n_vc > 1) ? $clog2(n_vc) : 1;
    endfunction

    localparam int VC_ID_WIDTH = vc_id_width(N_VIRT_CHN);

    typedef struct packed {
        logic [VC_ID_WIDTH-1:0] vc_id;
        logic [FLIT_WIDTH-1:0]  fdata;
    } s_link_flit_t;

endpackage

// File: rtl/ravenoc_link_slice_vc_fifo.sv
// Single-VC synchronous FIFO for the link slice; head entry is always visible on rd_data.
// Pointers wrap naturally because DEPTH is a power of two.
module ravenoc_link_vc_fifo
    import ravenoc_link_slice_pkg::*;
#(
    parameter int FLIT_W = FLIT_WIDTH,
    parameter int DEPTH  = LINK_SLICE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_noc,
    input  logic              arst_noc,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] wr_data,
    output logic [FLIT_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  cnt
);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_noc or negedge arst_noc) begin
        if (!arst_noc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; only occupancy decides what is valid.
    always_ff @(posedge clk_noc) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

`ifndef NO_ASSERTIONS
    localparam bit DEPTH_POW2 = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0);

    a_depth_pow2: assert property (@(posedge clk_noc) DEPTH_POW2)
        else $error("link fifo DEPTH must be a power of two >= 2");
    a_no_push_full: assert property (@(posedge clk_noc) disable iff (!arst_noc) !(push && full))
        else $error("link fifo push while full");
    a_no_pop_empty: assert property (@(posedge clk_noc) disable iff (!arst_noc) !(pop && empty))
        else $error("link fifo pop while empty");
`endif

endmodule

// File: rtl/ravenoc_link_slice.sv
// Elastic retiming stage on a mesh link: one FIFO per VC upstream, round-robin
// VC arbitration downstream. Ready to the sender comes from registered occupancy only.
module ravenoc_link_slice
    import ravenoc_link_slice_pkg::*;
#(
    parameter int N_VC   = N_VIRT_CHN,
    parameter int FLIT_W = FLIT_WIDTH,
    parameter int DEPTH  = LINK_SLICE_DEPTH
) (
    input  logic                          clk_noc,
    input  logic                          arst_noc,
    input  logic                          in_valid,
    input  logic [vc_id_width(N_VC)-1:0]  in_vc_id,
    input  logic [FLIT_W-1:0]             in_fdata,
    output logic [N_VC-1:0]               in_ready,
    output logic                          out_valid,
    output logic [vc_id_width(N_VC)-1:0]  out_vc_id,
    output logic [FLIT_W-1:0]             out_fdata,
    input  logic [N_VC-1:0]               out_ready,
    output logic                          empty_o
);

    localparam int VC_W  = vc_id_width(N_VC);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [N_VC-1:0]   push;
    logic [N_VC-1:0]   full;
    logic [N_VC-1:0]   empty;
    logic [N_VC-1:0]   cand;
    logic [N_VC-1:0]   grant;
    logic [FLIT_W-1:0] head [N_VC];
    logic [CNT_W-1:0]  cnt  [N_VC];
    logic [VC_W-1:0]   rr_ptr;
    logic [VC_W-1:0]   grant_idx;
    logic [VC_W-1:0]   idx;
    logic              found;
    logic              vc_legal;

    assign vc_legal = (int'(in_vc_id) < N_VC);

    for (genvar v = 0; v < N_VC; v++) begin : g_vc
        assign push[v] = in_valid && vc_legal && (int'(in_vc_id) == v) && !full[v];
        assign cand[v] = !empty[v] && out_ready[v];

        ravenoc_link_vc_fifo #(
            .FLIT_W (FLIT_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk_noc  (clk_noc),
            .arst_noc (arst_noc),
            .push     (push[v]),
            .pop      (grant[v]),
            .wr_data  (in_fdata),
            .rd_data  (head[v]),
            .full     (full[v]),
            .empty    (empty[v]),
            .cnt      (cnt[v])
        );
    end

    assign in_ready  = ~full;
    assign out_valid = |cand;

    // Search starts just after the last granted VC so every VC gets a turn.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 1; i <= N_VC; i++) begin
            idx = VC_W'((int'(rr_ptr) + i) % N_VC);
            if (!found && cand[idx]) begin
                found     = 1'b1;
                grant[idx] = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // One-hot AND-OR mux; yields zero when nothing is granted.
    always_comb begin
        out_fdata = '0;
        for (int v = 0; v < N_VC; v++) begin
            if (grant[v]) out_fdata = out_fdata | head[v];
        end
    end

    assign out_vc_id = grant_idx;

    always_comb begin
        empty_o = 1'b1;
        for (int v = 0; v < N_VC; v++) begin
            if (cnt[v] != '0) empty_o = 1'b0;
        end
    end

    always_ff @(posedge clk_noc or negedge arst_noc) begin
        if (!arst_noc) begin
            rr_ptr <= VC_W'(N_VC - 1);
        end else if (out_valid) begin
            rr_ptr <= grant_idx;
        end
    end

`ifndef NO_ASSERTIONS
    a_grant_onehot: assert property (@(posedge clk_noc) disable iff (!arst_noc)
        $onehot0(grant) && (out_valid == (|grant)))
        else $error("link slice grant not one-hot");
`endif

endmodule

// File: tb/tb_ravenoc_link_slice.sv
// Bench for ravenoc_link_slice: vector table for corner sequences, scoreboard for streaming,
// and a three-VC instance for the out-of-range VC id case.
module tb_ravenoc_link_slice;

    logic       clk_noc = 1'b0;
    logic       arst_noc = 1'b0;

    logic       in_valid = 1'b0;
    logic [0:0] in_vc_id = '0;
    logic [7:0] in_fdata = '0;
    logic [1:0] in_ready;
    logic       out_valid;
    logic [0:0] out_vc_id;
    logic [7:0] out_fdata;
    logic [1:0] out_ready = 2'b11;
    logic       empty_o;

    logic       in_valid3 = 1'b0;
    logic [1:0] in_vc_id3 = '0;
    logic [7:0] in_fdata3 = '0;
    logic [2:0] in_ready3;
    logic       out_valid3;
    logic [1:0] out_vc_id3;
    logic [7:0] out_fdata3;
    logic [2:0] out_ready3 = 3'b111;
    logic       empty3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_noc = ~clk_noc;

    ravenoc_link_slice #(.N_VC(2), .FLIT_W(8), .DEPTH(2)) dut (
        .clk_noc   (clk_noc),
        .arst_noc  (arst_noc),
        .in_valid  (in_valid),
        .in_vc_id  (in_vc_id),
        .in_fdata  (in_fdata),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_vc_id (out_vc_id),
        .out_fdata (out_fdata),
        .out_ready (out_ready),
        .empty_o   (empty_o)
    );

    ravenoc_link_slice #(.N_VC(3), .FLIT_W(8), .DEPTH(2)) dut3 (
        .clk_noc   (clk_noc),
        .arst_noc  (arst_noc),
        .in_valid  (in_valid3),
        .in_vc_id  (in_vc_id3),
        .in_fdata  (in_fdata3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_vc_id (out_vc_id3),
        .out_fdata (out_fdata3),
        .out_ready (out_ready3),
        .empty_o   (empty3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         rst;
        logic       iv;
        logic       vc;
        logic [7:0] d;
        logic [1:0] ordy;
        logic [1:0] e_irdy;
        logic       e_ov;
        logic       e_vc;
        logic [7:0] e_d;
        logic       e_empty;
    } vec_t;

    function automatic vec_t mk(input bit rst, input logic iv, input logic vc, input logic [7:0] d,
                                input logic [1:0] ordy, input logic [1:0] e_irdy, input logic e_ov,
                                input logic e_vc, input logic [7:0] e_d, input logic e_empty);
        vec_t r;
        r.rst = rst; r.iv = iv; r.vc = vc; r.d = d; r.ordy = ordy;
        r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_vc = e_vc; r.e_d = e_d; r.e_empty = e_empty;
        return r;
    endfunction

    // Asserts reset mid-cycle; the flush must show before any clock edge.
    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 2'b11;
        #1;
        arst_noc = 1'b0;
        #1;
        check("rst_async_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_async_empty", {31'd0, empty_o}, 32'd1);
        repeat (2) @(posedge clk_noc);
        #1 arst_noc = 1'b1;
    endtask

    vec_t vecs[$];
    logic [8:0] sb[$];
    logic [8:0] exp_item;

    initial begin
        // Backpressure, full FIFO with simultaneous pop, release
        vecs.push_back(mk(0, 1, 0, 8'hB1, 2'b00, 2'b11, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 1, 0, 8'hB2, 2'b00, 2'b11, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 8'hB3, 2'b00, 2'b10, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 8'hB3, 2'b01, 2'b10, 1, 0, 8'hB1, 0));
        vecs.push_back(mk(0, 1, 0, 8'hB3, 2'b01, 2'b11, 1, 0, 8'hB2, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2'b01, 2'b11, 1, 0, 8'hB3, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2'b11, 2'b11, 0, 0, 8'h00, 1));
        // Round-robin fairness from a fresh reset
        vecs.push_back(mk(1, 1, 0, 8'h10, 2'b00, 2'b11, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 1, 0, 8'h11, 2'b00, 2'b11, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 1, 8'h20, 2'b00, 2'b10, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 1, 8'h21, 2'b00, 2'b10, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2'b11, 2'b00, 1, 0, 8'h10, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2'b11, 2'b01, 1, 1, 8'h20, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2'b11, 2'b11, 1, 0, 8'h11, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2'b11, 2'b11, 1, 1, 8'h21, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2'b11, 2'b11, 0, 0, 8'h00, 1));
        // Per-VC isolation
        vecs.push_back(mk(0, 1, 0, 8'h30, 2'b00, 2'b11, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 1, 1, 8'h40, 2'b00, 2'b11, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2'b10, 2'b11, 1, 1, 8'h40, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2'b10, 2'b11, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2'b01, 2'b11, 1, 0, 8'h30, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2'b11, 2'b11, 0, 0, 8'h00, 1));
        // Reset with two flits stored
        vecs.push_back(mk(0, 1, 0, 8'h50, 2'b00, 2'b11, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 1, 0, 8'h51, 2'b00, 2'b11, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 2'b11, 2'b11, 0, 0, 8'h00, 1));

        // Reset / idle
        repeat (3) @(posedge clk_noc);
        #1;
        check("rst_in_ready", {30'd0, in_ready}, 32'h3);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_vc_id", {31'd0, out_vc_id}, 32'd0);
        check("rst_out_fdata", {24'd0, out_fdata}, 32'd0);
        check("rst_empty", {31'd0, empty_o}, 32'd1);
        arst_noc = 1'b1;
        @(negedge clk_noc);
        check("idle_in_ready", {30'd0, in_ready}, 32'h3);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_empty", {31'd0, empty_o}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            @(posedge clk_noc);
            #1;
            in_valid  = vecs[i].iv;
            in_vc_id  = vecs[i].vc;
            in_fdata  = vecs[i].d;
            out_ready = vecs[i].ordy;
            @(negedge clk_noc);
            check($sformatf("row%0d_in_ready", i), {30'd0, in_ready}, {30'd0, vecs[i].e_irdy});
            check($sformatf("row%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            check($sformatf("row%0d_out_vc_id", i), {31'd0, out_vc_id}, {31'd0, vecs[i].e_vc});
            check($sformatf("row%0d_out_fdata", i), {24'd0, out_fdata}, {24'd0, vecs[i].e_d});
            check($sformatf("row%0d_empty", i), {31'd0, empty_o}, {31'd0, vecs[i].e_empty});
        end

        // Single-VC streaming: one flit per cycle, one cycle latency, no bubbles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_noc);
            #1;
            in_valid  = (i < 8);
            in_vc_id  = 1'b0;
            in_fdata  = 8'(8'hA1 + i);
            out_ready = 2'b11;
            if (i < 8) sb.push_back({1'b0, 8'(8'hA1 + i)});
            @(negedge clk_noc);
            check($sformatf("stream%0d_in_ready0", i), {31'd0, in_ready[0]}, 32'd1);
            check($sformatf("stream%0d_out_valid", i), {31'd0, out_valid},
                  {31'd0, (i >= 1 && i <= 8) ? 1'b1 : 1'b0});
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stream%0d_unexpected: got flit %0h, expected none", i, out_fdata);
                end else begin
                    exp_item = sb.pop_front();
                    check($sformatf("stream%0d_vc", i), {31'd0, out_vc_id}, {31'd0, exp_item[8]});
                    check($sformatf("stream%0d_data", i), {24'd0, out_fdata}, {24'd0, exp_item[7:0]});
                end
            end
        end
        check("stream_sb_drained", sb.size(), 32'd0);

        // Out-of-range VC id on a three-VC slice is ignored
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_noc);
            #1;
            in_valid3 = 1'b1;
            in_vc_id3 = 2'd3;
            in_fdata3 = 8'hEE;
            @(negedge clk_noc);
            check($sformatf("ill%0d_empty", k), {31'd0, empty3}, 32'd1);
            check($sformatf("ill%0d_in_ready", k), {29'd0, in_ready3}, 32'h7);
            check($sformatf("ill%0d_out_valid", k), {31'd0, out_valid3}, 32'd0);
        end
        @(posedge clk_noc);
        #1;
        in_vc_id3 = 2'd2;
        in_fdata3 = 8'h77;
        @(negedge clk_noc);
        check("ill_after_empty", {31'd0, empty3}, 32'd1);
        @(posedge clk_noc);
        #1;
        in_valid3 = 1'b0;
        @(negedge clk_noc);
        check("vc2_out_valid", {31'd0, out_valid3}, 32'd1);
        check("vc2_out_vc_id", {30'd0, out_vc_id3}, 32'd2);
        check("vc2_out_fdata", {24'd0, out_fdata3}, 32'h77);
        check("vc2_empty", {31'd0, empty3}, 32'd0);
        @(posedge clk_noc);
        #1;
        @(negedge clk_noc);
        check("vc2_drained", {31'd0, empty3}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
